drive_cmd_arbiter: RTL
======================

Name: drive_cmd_arbiter

Overview:
- Owns the two-wheel drive resource (direction pins plus PWM duty) and shares it between three requesters.
- Requesters, highest priority first: emergency stop (obstacle sensor or stop command), autonomous return sequencer, manual Bluetooth command stream.
- Enforces a minimum dwell time and a stopped dead-time before any direction reversal.
- Runs a watchdog that stops the car when the manual stream goes silent.

Parameters:
- DEAD_TICKS, 4: ticks held at Stop before a reversing code is applied.
- MIN_DWELL, 2: ticks a code must persist before an equal- or lower-priority source may change it.
- WDOG_TICKS, 64: ticks without man_valid before a manual-owned drive is forced to Stop.
- RAMP_STEP, 32: duty increment per tick (DRIVE_RAMP_EN only).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- tick  in  1  single-cycle pacing strobe; all counters advance only on tick.
- estop  in  1  level; emergency stop request.
- man_valid  in  1  single-cycle strobe; man_cmd is valid.
- man_cmd  in  8  Bluetooth command byte.
- auto_req  in  1  level; autonomous sequencer wants the drive.
- auto_code  in  3  motor code requested by the sequencer.
- motor_code  out  3  applied code.
- left  out  2  IN1/IN2.
- right  out  2  IN3/IN4.
- duty  out  8  PWM duty for ENA/ENB.
- owner  out  2  current owner: 0 none, 1 manual, 2 auto, 3 estop.
- dead_active  out  1  high while in the DEAD state.
- wdog_trip  out  1  sticky; set by a watchdog trip, cleared by the next man_valid.

Behaviour:
- Reset values: motor_code=0, left=00, right=00, duty=0, owner=0, dead_active=0, wdog_trip=0. All counters and pending registers cleared. State IDLE.
- Motor code mapping and pins {left,right}:
  - 0 Stop: 00,00
  - 1 Forward: 01,01
  - 2 Backward: 10,10
  - 3 RightFwd: 01,00
  - 4 LeftFwd: 00,01
  - 5 SpinLeft: 10,01
  - 6 SpinRight: 01,10
  - 7: treated as Stop.
- left/right/duty are registered from motor_code and state, with one clk of latency.
- Manual decode: bytes 10..16 map to codes 0..6. Any other byte is ignored, but it still feeds the watchdog.
- man_valid latches the decoded code into man_pend on the same clk edge; a newer strobe overwrites it. man_pend is consumed at the next tick.
- estop:
  - Sampled every clk, not gated by tick.
  - Within 1 clk of assertion: state ESTOP, motor_code=0, owner=3, duty=0.
  - On deassertion: next tick goes to IDLE. man_pend is discarded.
- Arbitration happens on tick only. Candidate order: auto (if auto_req) > man_pend (if present) > none.
  - A higher-priority candidate preempts at any tick, regardless of dwell.
  - Equal- or lower-priority changes wait until dwell_cnt >= MIN_DWELL; a pending manual code is held until then.
- Reversal: if either side goes from 01 to 10 or 10 to 01 between the current and new code:
  - Enter DEAD with motor_code=0 and dead_active=1 for DEAD_TICKS ticks.
  - Then apply the stored new code.
  - A higher-priority request arriving during DEAD replaces the stored code; the DEAD count is not restarted.
- States:
  - IDLE: code 0, owner 0.
  - RUN: code applied; dwell_cnt saturates at MIN_DWELL.
  - DEAD: as described under Reversal.
  - ESTOP: as described under estop.
  - RUN with code 0 and no candidate returns to IDLE.
- Dropping auto_req while auto owns the drive: next tick falls back to man_pend if present, otherwise Stop/IDLE.
- Watchdog:
  - Counts ticks while owner=1; reset by man_valid.
  - At WDOG_TICKS: code=0, owner=0, wdog_trip=1.
- Simultaneous tick and man_valid: the strobe's byte is the one consumed.
- Counters saturate and never wrap.

Optional Feature:
DRIVE_RAMP_EN:
- Defined: on every applied nonzero code change, duty restarts at RAMP_STEP and adds RAMP_STEP per tick, saturating at 255. duty=0 for code 0, DEAD and ESTOP.
- Undefined: duty=255 whenever the applied code is nonzero, else 0. RAMP_STEP is unused.

Test Plan:
- Reset low mid-RUN (code 1) -> all outputs zero within 1 clk; no tick needed.
- man_cmd=11 then tick -> code 1, left=01, right=01, owner=1, duty=255 (ramp off).
- Code 1 running, man_cmd=12 after dwell -> 4 ticks of code 0 with dead_active=1, then code 2, left=10, right=10.
- Manual code 1 active, auto_req=1 with auto_code=4 -> next tick code 4, owner=2, no dead-time. Drop auto_req -> Stop/IDLE.
- estop pulse between ticks -> code 0, owner=3 within 1 clk. Release -> IDLE at next tick.
- Manual code 1, then 64 ticks without man_valid -> code 0, owner=0, wdog_trip=1. Next man_valid clears wdog_trip.

Source files
------------

// File: rtl/drive_cmd_arbiter.sv
// drive_cmd_arbiter: shares the two-wheel drive between estop, auto sequencer and manual stream
// Ports: clk, rst (async active-low); tick pacing strobe; estop level; man_valid/man_cmd manual
// byte stream; auto_req/auto_code sequencer request; motor_code/left/right/duty drive outputs;
// owner (0 none,1 manual,2 auto,3 estop); dead_active; wdog_trip (sticky until next man_valid).
// Optional DRIVE_RAMP_EN: duty ramps by RAMP_STEP per tick after each nonzero code change.
module drive_cmd_arbiter #(
  parameter int DEAD_TICKS = 4,
  parameter int MIN_DWELL = 2,
`ifdef DRIVE_RAMP_EN
  parameter int RAMP_STEP = 32,
`endif
  parameter int WDOG_TICKS = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       estop,
  input  logic       man_valid,
  input  logic [7:0] man_cmd,
  input  logic       auto_req,
  input  logic [2:0] auto_code,
  output logic [2:0] motor_code,
  output logic [1:0] left,
  output logic [1:0] right,
  output logic [7:0] duty,
  output logic [1:0] owner,
  output logic       dead_active,
  output logic       wdog_trip
);
  typedef enum logic [1:0] {IDLE, RUN, DEAD, ESTOP} state_t;
  state_t state, state_nx;
  logic [2:0] code_nx, pend_code, pend_nx, man_code, mc_nx, man_dec, man_c, cand_code;
  logic [1:0] owner_nx, cand_own;
  logic [7:0] dwell, dwell_nx, dead, dead_nx, run_duty;
  logic [15:0] wdog, wdog_nx;
  logic man_vld, mv_nx, trip_nx, man_ok, man_av, wd_hit, apply, take;
  function automatic logic [3:0] pins(input logic [2:0] c);
    case (c)
      3'd1: pins = 4'b0101;
      3'd2: pins = 4'b1010;
      3'd3: pins = 4'b0100;
      3'd4: pins = 4'b0001;
      3'd5: pins = 4'b1001;
      3'd6: pins = 4'b0110;
      default: pins = 4'b0000;
    endcase
  endfunction
  // A side flipping between 01 and 10 means a direction reversal.
  function automatic logic rev(input logic [3:0] a, input logic [3:0] b);
    rev = (a[3:2] == 2'b01 && b[3:2] == 2'b10) || (a[3:2] == 2'b10 && b[3:2] == 2'b01) ||
          (a[1:0] == 2'b01 && b[1:0] == 2'b10) || (a[1:0] == 2'b10 && b[1:0] == 2'b01);
  endfunction
  assign man_ok = man_valid && man_cmd >= 8'd10 && man_cmd <= 8'd16;
  assign man_dec = 3'(man_cmd - 8'd10);
  // A strobe coinciding with tick wins over the older pending byte.
  assign man_av = man_ok || man_vld;
  assign man_c = man_ok ? man_dec : man_code;
  assign cand_own = auto_req ? 2'd2 : man_av ? 2'd1 : 2'd0;
  assign cand_code = auto_req ? (auto_code == 3'd7 ? 3'd0 : auto_code) : man_av ? man_c : 3'd0;
  assign wd_hit = owner == 2'd1 && !man_valid && wdog == 16'(WDOG_TICKS - 1);
  assign dead_active = state == DEAD;
  always_comb begin
    state_nx = state;
    code_nx = motor_code;
    owner_nx = owner;
    dwell_nx = dwell;
    dead_nx = dead;
    pend_nx = pend_code;
    wdog_nx = (man_valid || owner != 2'd1) ? '0 : (tick ? (wd_hit ? '0 : wdog + 16'd1) : wdog);
    trip_nx = wdog_trip & ~man_valid;
    mv_nx = man_ok ? 1'b1 : man_vld;
    mc_nx = man_ok ? man_dec : man_code;
    apply = 1'b0;
    take = 1'b0;
    if (estop) begin
      state_nx = ESTOP;
      code_nx = '0;
      owner_nx = 2'd3;
      mv_nx = 1'b0;
    end else if (tick) begin
      if (wd_hit) begin
        state_nx = IDLE;
        code_nx = '0;
        owner_nx = '0;
        trip_nx = 1'b1;
      end else begin
        case (state)
          ESTOP: begin
            state_nx = IDLE;
            owner_nx = '0;
            mv_nx = 1'b0;
          end
          IDLE: apply = cand_own != 2'd0;
          RUN: begin
            // Preemption ignores dwell; auto releasing falls back at once; same-owner changes wait.
            if (cand_own > owner || (owner == 2'd2 && !auto_req) ||
                (cand_own == owner && cand_own != 2'd0 && dwell >= 8'(MIN_DWELL) &&
                 (owner == 2'd1 || cand_code != motor_code)))
              apply = 1'b1;
            else if (cand_own == 2'd0 && motor_code == 3'd0) begin
              state_nx = IDLE;
              owner_nx = '0;
            end else
              dwell_nx = dwell >= 8'(MIN_DWELL) ? dwell : dwell + 8'd1;
          end
          default: begin
            // Higher priority swaps the stored code but keeps the dead-time count running.
            if (cand_own > owner) begin
              pend_nx = cand_code;
              owner_nx = cand_own;
              take = cand_own == 2'd1;
            end
            if (dead == 8'(DEAD_TICKS - 1)) begin
              state_nx = RUN;
              code_nx = pend_nx;
              dwell_nx = '0;
            end else
              dead_nx = dead + 8'd1;
          end
        endcase
        if (apply) begin
          take = cand_own == 2'd1;
          owner_nx = cand_own;
          if (rev(pins(motor_code), pins(cand_code))) begin
            state_nx = DEAD;
            code_nx = '0;
            dead_nx = '0;
            pend_nx = cand_code;
          end else begin
            state_nx = (cand_own == 2'd0 && cand_code == 3'd0) ? IDLE : RUN;
            code_nx = cand_code;
            dwell_nx = '0;
          end
        end
        if (take) mv_nx = 1'b0;
      end
    end
  end
`ifdef DRIVE_RAMP_EN
  logic [7:0] ramp;
  always_ff @(posedge clk or negedge rst)
    if (!rst) ramp <= '0;
    else if (state_nx == RUN && code_nx != 3'd0 && (state != RUN || code_nx != motor_code)) ramp <= 8'(RAMP_STEP);
    else if (tick && state == RUN) ramp <= (ramp > 8'(255 - RAMP_STEP)) ? 8'hff : ramp + 8'(RAMP_STEP);
  assign run_duty = ramp;
`else
  assign run_duty = 8'hff;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      motor_code <= '0;
      owner <= '0;
      dwell <= '0;
      dead <= '0;
      wdog <= '0;
      wdog_trip <= 1'b0;
      man_vld <= 1'b0;
      man_code <= '0;
      pend_code <= '0;
      left <= '0;
      right <= '0;
      duty <= '0;
    end else begin
      state <= state_nx;
      motor_code <= code_nx;
      owner <= owner_nx;
      dwell <= dwell_nx;
      dead <= dead_nx;
      wdog <= wdog_nx;
      wdog_trip <= trip_nx;
      man_vld <= mv_nx;
      man_code <= mc_nx;
      pend_code <= pend_nx;
      {left, right} <= pins(motor_code);
      duty <= estop ? 8'd0 : (state == RUN && motor_code != 3'd0) ? run_duty : 8'd0;
    end
endmodule
